// File: rtl/ppi_bus_master.sv
// ppi_bus_master
// CPU-side initiator for an 8255A PPI. Each accepted one-word command becomes a
// complete, timed PPI bus cycle: CS_n and A1A0 (plus write data) are set up,
// RD_n or WR_n is pulsed low, then CS_n/A/data are held before the bus is released.
// Only one command is in flight; a completion pulse reports the result.
//
// Parameters
//   SETUP_CYC  cycles CS_n/A/data are valid before the strobe falls (>=1)
//   PULSE_CYC  cycles the strobe is held low (>=1)
//   HOLD_CYC   cycles CS_n/A/data are held after the strobe rises (>=1)
//
// Ports
//   Clock     in   rising-edge system clock
//   Reset     in   synchronous active-high reset
//   CmdValid  in   command request
//   CmdReady  out  command can be accepted this cycle (IDLE only)
//   CmdRead   in   1 = read, 0 = write
//   CmdAddr   in   A1A0: 00 port A, 01 port B, 10 port C, 11 control word
//   CmdData   in   write data / control word
//   RspValid  out  one-cycle completion pulse
//   RspErr    out  command rejected, no bus cycle was run
//   RspData   out  captured read byte, 0x00 for writes and errors
//   CS_n      out  PPI chip select, active low
//   A         out  PPI address A1A0
//   RD_n      out  PPI read strobe, active low
//   WR_n      out  PPI write strobe, active low
//   DataOut   out  data driven toward the PPI
//   DataOE    out  1 while DataOut should drive the shared data bus
//   DataIn    in   data bus as seen from the PPI
//   Busy      out  bus cycle in progress

module ppi_bus_master #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CmdValid,
    output logic       CmdReady,
    input  logic       CmdRead,
    input  logic [1:0] CmdAddr,
    input  logic [7:0] CmdData,
    output logic       RspValid,
    output logic       RspErr,
    output logic [7:0] RspData,
    output logic       CS_n,
    output logic [1:0] A,
    output logic       RD_n,
    output logic       WR_n,
    output logic [7:0] DataOut,
    output logic       DataOE,
    input  logic [7:0] DataIn,
    output logic       Busy
);

    // One shared down-counter serves all three timed phases, so it only needs
    // to hold the largest phase length minus one.
    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ?
                             ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                             ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          isRead_q;
    logic [7:0]    rdData_q;
    logic          cmdReady_q;
    logic          rspValid_q;
    logic          rspErr_q;
    logic [7:0]    rspData_q;
    logic          csN_q;
    logic [1:0]    addr_q;
    logic          rdN_q;
    logic          wrN_q;
    logic [7:0]    dataOut_q;
    logic          dataOe_q;

    // All bus pins come straight from registers: the values for cycle N are
    // decided at the edge that starts cycle N, so pin changes line up with the
    // phase boundaries and nothing on Cmd* reaches the pins combinationally.
    // The completion pulse and its data default to zero every cycle and are
    // only raised for the single cycle following a finished or rejected command.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            isRead_q   <= 1'b0;
            rdData_q   <= 8'h00;
            cmdReady_q <= 1'b1;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspData_q  <= 8'h00;
            csN_q      <= 1'b1;
            addr_q     <= 2'b00;
            rdN_q      <= 1'b1;
            wrN_q      <= 1'b1;
            dataOut_q  <= 8'h00;
            dataOe_q   <= 1'b0;
        end else begin
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspData_q  <= 8'h00;

            case (state_q)
                IDLE: begin
                    if (CmdValid) begin
                        // The 8255 cannot read back its control word, so that
                        // request is answered with an error and no bus cycle.
                        if (CmdRead && (CmdAddr == 2'b11)) begin
                            rspValid_q <= 1'b1;
                            rspErr_q   <= 1'b1;
                        end else begin
                            state_q    <= SETUP;
                            cnt_q      <= CW'(SETUP_CYC - 1);
                            isRead_q   <= CmdRead;
                            cmdReady_q <= 1'b0;
                            csN_q      <= 1'b0;
                            addr_q     <= CmdAddr;
                            dataOe_q   <= ~CmdRead;
                            dataOut_q  <= CmdRead ? 8'h00 : CmdData;
                        end
                    end
                end

                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= PULSE;
                        cnt_q   <= CW'(PULSE_CYC - 1);
                        rdN_q   <= ~isRead_q;
                        wrN_q   <= isRead_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                PULSE: begin
                    // The edge that ends the pulse is also the read sample point.
                    if (cnt_q == '0) begin
                        state_q <= HOLD;
                        cnt_q   <= CW'(HOLD_CYC - 1);
                        rdN_q   <= 1'b1;
                        wrN_q   <= 1'b1;
                        if (isRead_q) begin
                            rdData_q <= DataIn;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                HOLD: begin
                    // Releasing the bus and reporting completion happen together;
                    // CmdReady is back up in the same cycle as RspValid.
                    if (cnt_q == '0) begin
                        state_q    <= IDLE;
                        cmdReady_q <= 1'b1;
                        csN_q      <= 1'b1;
                        addr_q     <= 2'b00;
                        dataOe_q   <= 1'b0;
                        dataOut_q  <= 8'h00;
                        rspValid_q <= 1'b1;
                        rspData_q  <= isRead_q ? rdData_q : 8'h00;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign CmdReady = cmdReady_q;
    assign RspValid = rspValid_q;
    assign RspErr   = rspErr_q;
    assign RspData  = rspData_q;
    assign CS_n     = csN_q;
    assign A        = addr_q;
    assign RD_n     = rdN_q;
    assign WR_n     = wrN_q;
    assign DataOut  = dataOut_q;
    assign DataOE   = dataOe_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb_ppi_bus_master
// Drives two instances of ppi_bus_master: one with the default 2/4/2 timing and
// one with 1/1/1 timing. Each observed cycle is compared against an expected
// pin pattern built from the command, the cycle number and the phase lengths.
// Packed pin vector layout:
// {CS_n, A[1:0], RD_n, WR_n, DataOE, DataOut[7:0], RspValid, RspErr, RspData[7:0], CmdReady, Busy}

module tb_ppi_bus_master;

    typedef struct {
        logic       rd;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] busByte;
        logic [7:0] expRsp;
        logic       expErr;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       CmdValid1, CmdValid2;
    logic       CmdRead;
    logic [1:0] CmdAddr;
    logic [7:0] CmdData;
    logic [7:0] DataIn;

    logic       CmdReady1, RspValid1, RspErr1, CS_n1, RD_n1, WR_n1, DataOE1, Busy1;
    logic [1:0] A1;
    logic [7:0] RspData1, DataOut1;
    logic       CmdReady2, RspValid2, RspErr2, CS_n2, RD_n2, WR_n2, DataOE2, Busy2;
    logic [1:0] A2;
    logic [7:0] RspData2, DataOut2;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[5];

    always #5 Clock = ~Clock;

    ppi_bus_master dut (
        .Clock(Clock), .Reset(Reset),
        .CmdValid(CmdValid1), .CmdReady(CmdReady1),
        .CmdRead(CmdRead), .CmdAddr(CmdAddr), .CmdData(CmdData),
        .RspValid(RspValid1), .RspErr(RspErr1), .RspData(RspData1),
        .CS_n(CS_n1), .A(A1), .RD_n(RD_n1), .WR_n(WR_n1),
        .DataOut(DataOut1), .DataOE(DataOE1), .DataIn(DataIn), .Busy(Busy1)
    );

    ppi_bus_master #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dutFast (
        .Clock(Clock), .Reset(Reset),
        .CmdValid(CmdValid2), .CmdReady(CmdReady2),
        .CmdRead(CmdRead), .CmdAddr(CmdAddr), .CmdData(CmdData),
        .RspValid(RspValid2), .RspErr(RspErr2), .RspData(RspData2),
        .CS_n(CS_n2), .A(A2), .RD_n(RD_n2), .WR_n(WR_n2),
        .DataOut(DataOut2), .DataOE(DataOE2), .DataIn(DataIn), .Busy(Busy2)
    );

    function automatic logic [25:0] observe(input int sel);
        if (sel == 1)
            return {CS_n1, A1, RD_n1, WR_n1, DataOE1, DataOut1,
                    RspValid1, RspErr1, RspData1, CmdReady1, Busy1};
        return {CS_n2, A2, RD_n2, WR_n2, DataOE2, DataOut2,
                RspValid2, RspErr2, RspData2, CmdReady2, Busy2};
    endfunction

    function automatic logic [25:0] mkExp(
        input logic csN, input logic [1:0] a, input logic rdN, input logic wrN,
        input logic oe, input logic [7:0] dout, input logic rv, input logic re,
        input logic [7:0] rdat, input logic ready, input logic busy);
        return {csN, a, rdN, wrN, oe, dout, rv, re, rdat, ready, busy};
    endfunction

    // Bus released, no response, ready for a command.
    function automatic logic [25:0] idleExp();
        return mkExp(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endfunction

    task automatic checkOutput(input string name, input int sel, input int cyc,
                               input logic [25:0] exp);
        logic [25:0] act;
        act = observe(sel);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic setValid(input int sel, input logic v);
        if (sel == 1) CmdValid1 = v;
        else          CmdValid2 = v;
    endtask

    // Presents a command, lets it be accepted at the next rising edge (E0), then
    // walks cycles 1..S+P+H+1 comparing every pin. Returns at the falling edge
    // of the response cycle so a follow-on command can be accepted there.
    task automatic applyStimulus(input int sel, input int s, input int p, input int h,
                                 input vec_t v, input string name);
        int n;
        logic inBus, strobe;
        CmdRead = v.rd;
        CmdAddr = v.addr;
        CmdData = v.data;
        setValid(sel, 1'b1);
        @(posedge Clock);
        #1;
        setValid(sel, 1'b0);
        CmdRead = ~v.rd;
        CmdAddr = ~v.addr;
        CmdData = 8'hEE;
        if (v.expErr) begin
            DataIn = 8'hFF;
            @(negedge Clock);
            checkOutput(name, sel, 1,
                mkExp(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0));
        end else begin
            n = s + p + h + 1;
            for (int k = 1; k <= n; k++) begin
                DataIn = (v.rd && k > s && k <= s + p) ? v.busByte : 8'hFF;
                @(negedge Clock);
                inBus  = (k <= s + p + h);
                strobe = (k > s) && (k <= s + p);
                checkOutput(name, sel, k,
                    mkExp(~inBus, inBus ? v.addr : 2'b00,
                          ~(strobe & v.rd), ~(strobe & ~v.rd),
                          inBus & ~v.rd, (inBus & ~v.rd) ? v.data : 8'h00,
                          k == n, 1'b0, (k == n) ? v.expRsp : 8'h00,
                          ~inBus, inBus));
                if (k < n) begin
                    @(posedge Clock);
                    #1;
                end
            end
        end
    endtask

    task automatic idleCycles(input int sel, input int count, input string name);
        for (int i = 0; i < count; i++) begin
            @(posedge Clock);
            #1;
            DataIn = 8'hFF;
            @(negedge Clock);
            checkOutput(name, sel, i, idleExp());
        end
    endtask

    initial begin
        vec_t v;

        vecs[0] = '{rd: 1'b0, addr: 2'b11, data: 8'h82, busByte: 8'hFF, expRsp: 8'h00, expErr: 1'b0};
        vecs[1] = '{rd: 1'b1, addr: 2'b01, data: 8'h00, busByte: 8'hA5, expRsp: 8'hA5, expErr: 1'b0};
        vecs[2] = '{rd: 1'b1, addr: 2'b00, data: 8'h00, busByte: 8'h3C, expRsp: 8'h3C, expErr: 1'b0};
        vecs[3] = '{rd: 1'b0, addr: 2'b10, data: 8'h55, busByte: 8'hFF, expRsp: 8'h00, expErr: 1'b0};
        vecs[4] = '{rd: 1'b1, addr: 2'b11, data: 8'h00, busByte: 8'hFF, expRsp: 8'h00, expErr: 1'b1};

        Reset     = 1'b1;
        CmdValid1 = 1'b0;
        CmdValid2 = 1'b0;
        CmdRead   = 1'b0;
        CmdAddr   = 2'b00;
        CmdData   = 8'h00;
        DataIn    = 8'hFF;

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checkOutput("reset_default", 1, 0, idleExp());
        checkOutput("reset_fast", 2, 0, idleExp());
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        idleCycles(1, 1, "post_reset_idle");

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 2, 4, 2, vecs[i], $sformatf("vec%0d", i));
            idleCycles(1, 2, $sformatf("vec%0d_after", i));
        end

        // Back-to-back: second command accepted in the first one's RspValid cycle,
        // leaving exactly one CS_n-high cycle between the two bus cycles.
        v = '{rd: 1'b0, addr: 2'b11, data: 8'h0F, busByte: 8'hFF, expRsp: 8'h00, expErr: 1'b0};
        applyStimulus(1, 2, 4, 2, v, "b2b_first");
        v = '{rd: 1'b0, addr: 2'b00, data: 8'h3C, busByte: 8'hFF, expRsp: 8'h00, expErr: 1'b0};
        applyStimulus(1, 2, 4, 2, v, "b2b_second");
        idleCycles(1, 2, "b2b_after");

        // Reset during cycle 4 of a write aborts the cycle with no response.
        @(posedge Clock);
        #1;
        CmdRead   = 1'b0;
        CmdAddr   = 2'b11;
        CmdData   = 8'h82;
        CmdValid1 = 1'b1;
        @(posedge Clock);
        #1;
        CmdValid1 = 1'b0;
        repeat (3) begin
            @(posedge Clock);
            #1;
        end
        @(negedge Clock);
        checkOutput("rst_mid_cycle4", 1, 4,
            mkExp(1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 8'h82, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1));
        Reset     = 1'b1;
        CmdValid1 = 1'b1;
        CmdRead   = 1'b0;
        CmdAddr   = 2'b10;
        CmdData   = 8'h99;
        @(posedge Clock);
        #1;
        @(negedge Clock);
        checkOutput("rst_abort", 1, 5, idleExp());
        @(posedge Clock);
        #1;
        @(negedge Clock);
        checkOutput("rst_ignores_cmd", 1, 6, idleExp());
        @(posedge Clock);
        #1;
        Reset     = 1'b0;
        CmdValid1 = 1'b0;
        @(negedge Clock);
        checkOutput("rst_released", 1, 7, idleExp());
        idleCycles(1, 10, "rst_no_rsp");
        v = '{rd: 1'b0, addr: 2'b11, data: 8'h82, busByte: 8'hFF, expRsp: 8'h00, expErr: 1'b0};
        applyStimulus(1, 2, 4, 2, v, "rst_recover");
        idleCycles(1, 1, "rst_recover_after");

        // Minimum timing instance.
        v = '{rd: 1'b0, addr: 2'b10, data: 8'h5A, busByte: 8'hFF, expRsp: 8'h00, expErr: 1'b0};
        applyStimulus(2, 1, 1, 1, v, "fast_write");
        idleCycles(2, 1, "fast_write_after");
        v = '{rd: 1'b1, addr: 2'b00, data: 8'h00, busByte: 8'h77, expRsp: 8'h77, expErr: 1'b0};
        applyStimulus(2, 1, 1, 1, v, "fast_read");
        idleCycles(2, 1, "fast_read_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
